// File: rtl/mc_dst_encoder_pkg.sv
// Shared types for the multicast destination encoder, plus the global width macros.
// This file also carries the router-wide defines, so it is compiled before anything that uses them.
`ifndef MC_GLOBAL_DEFS
`define MC_GLOBAL_DEFS
`define DST_LIST_WIDTH 16
`define NUM_PORT 5
`endif

package mc_dst_encoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_FORM     = 2'd2,
    ST_WAIT_INJ = 2'd3
  } state_e;

  localparam int DST_LIST_W = `DST_LIST_WIDTH;

  typedef logic [DST_LIST_W-1:0] dst_list_t;

  // True when more than one destination bit is set (clearing the lowest set bit leaves something).
  function automatic logic is_multi(input dst_list_t v);
    return (v & (v - dst_list_t'(1))) != '0;
  endfunction

endpackage

// File: rtl/mc_starve_ctr.sv
// Saturating injection-wait counter; starve asserts once the count reaches TH.
module mc_starve_ctr #(
  parameter int TH = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic starve
);

  localparam int              CNT_W = $clog2(TH + 1);
  localparam logic [CNT_W-1:0] TH_C = CNT_W'(TH);

  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (clr)                        count_d = '0;
    else if (inc && count_q != TH_C) count_d = count_q + CNT_W'(1);
  end

  // NOTE: sequential state is updated with <= so all flops sample pre-edge values together.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign starve = (count_q == TH_C);

endmodule

// File: rtl/mc_dst_encoder.sv
// Multicast source encoder: ORs NI destination beats into a bitmap, peels off the local copy,
// and holds the remaining flit on the router injection port until granted.
module mc_dst_encoder
  import mc_dst_encoder_pkg::*;
#(
  parameter int NODE_ID   = 0,
  parameter int NUM_NODE  = 16,
  parameter int ID_W      = 5,
  parameter int PAYLOAD_W = 32,
  parameter int STARVE_TH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dst_valid,
  input  logic [ID_W-1:0]            dst_id,
  input  logic                       dst_last,
  input  logic [PAYLOAD_W-1:0]       dst_payload,
  output logic                       dst_ready,
  output logic                       inj_valid,
  input  logic                       inj_grant,
  output logic [`DST_LIST_WIDTH-1:0] inj_dstList,
  output logic                       inj_mc,
  output logic [PAYLOAD_W-1:0]       inj_payload,
  output logic                       local_valid,
  output logic [PAYLOAD_W-1:0]       local_payload,
  output logic                       starve,
  output logic                       err_id
);

  localparam logic [ID_W:0] NUM_NODE_L = (ID_W + 1)'(NUM_NODE);

  state_e                 state_q, state_d;
  dst_list_t              acc_q, acc_d;
  logic [PAYLOAD_W-1:0]   payload_q, payload_d;
  logic                   inj_valid_q, inj_valid_d;
  dst_list_t              inj_dst_list_q, inj_dst_list_d;
  logic                   inj_mc_q, inj_mc_d;
  logic [PAYLOAD_W-1:0]   inj_payload_q, inj_payload_d;
  logic                   local_valid_q, local_valid_d;
  logic [PAYLOAD_W-1:0]   local_payload_q, local_payload_d;
  logic                   err_id_q, err_id_d;

  logic      accept;
  logic      id_ok;
  dst_list_t rem;

  // Ready is gated by reset so the NI sees it low during the reset cycle itself.
  assign dst_ready = ~reset & ((state_q == ST_IDLE) | (state_q == ST_COLLECT));
  assign accept    = dst_valid & dst_ready;
  assign id_ok     = {1'b0, dst_id} < NUM_NODE_L;
  assign rem       = acc_q & ~(dst_list_t'(1) << NODE_ID);

  always_comb begin
    state_d         = state_q;
    acc_d           = acc_q;
    payload_d       = payload_q;
    inj_valid_d     = inj_valid_q;
    inj_dst_list_d  = inj_dst_list_q;
    inj_mc_d        = inj_mc_q;
    inj_payload_d   = inj_payload_q;
    local_valid_d   = 1'b0;
    local_payload_d = local_payload_q;
    err_id_d        = err_id_q | (accept & ~id_ok);

    unique case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (accept) begin
          if (id_ok) acc_d = acc_q | (dst_list_t'(1) << dst_id);
          if (dst_last) begin
            state_d   = ST_FORM;
            payload_d = dst_payload;
          end else begin
            state_d   = ST_COLLECT;
          end
        end
      end
      ST_FORM: begin
        acc_d = '0;
        if (acc_q[NODE_ID]) begin
          local_valid_d   = 1'b1;
          local_payload_d = payload_q;
        end
        if (rem == '0) begin
          state_d = ST_IDLE;
        end else begin
          state_d        = ST_WAIT_INJ;
          inj_valid_d    = 1'b1;
          inj_dst_list_d = rem;
          inj_mc_d       = is_multi(rem);
          inj_payload_d  = payload_q;
        end
      end
      ST_WAIT_INJ: begin
        if (inj_grant) begin
          state_d        = ST_IDLE;
          inj_valid_d    = 1'b0;
          inj_dst_list_d = '0;
          inj_mc_d       = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      acc_q           <= '0;
      payload_q       <= '0;
      inj_valid_q     <= 1'b0;
      inj_dst_list_q  <= '0;
      inj_mc_q        <= 1'b0;
      inj_payload_q   <= '0;
      local_valid_q   <= 1'b0;
      local_payload_q <= '0;
      err_id_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      acc_q           <= acc_d;
      payload_q       <= payload_d;
      inj_valid_q     <= inj_valid_d;
      inj_dst_list_q  <= inj_dst_list_d;
      inj_mc_q        <= inj_mc_d;
      inj_payload_q   <= inj_payload_d;
      local_valid_q   <= local_valid_d;
      local_payload_q <= local_payload_d;
      err_id_q        <= err_id_d;
    end
  end

  mc_starve_ctr #(.TH(STARVE_TH)) u_starve_ctr (
    .clk    (clk),
    .reset  (reset),
    .clr    (~inj_valid_q | inj_grant),
    .inc    (inj_valid_q & ~inj_grant),
    .starve (starve)
  );

  assign inj_valid     = inj_valid_q;
  assign inj_dstList   = inj_dst_list_q;
  assign inj_mc        = inj_mc_q;
  assign inj_payload   = inj_payload_q;
  assign local_valid   = local_valid_q;
  assign local_payload = local_payload_q;
  assign err_id        = err_id_q;

endmodule
